adder_fault_locator: RTL and testbench

ADDER_FAULT_LOCATOR -- requirements
Module: adder_fault_locator

---
 rtl/adder_fault_locator.sv | 187 ++++++++++++++++++
 tb/tb_adder_fault_locator.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_fault_locator.sv
// Built-in self test for a WIDTH-bit ripple adder: walks every full-adder stage
// through all 8 input combinations and records which stages produced a wrong sum.
module adder_fault_locator #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned SETTLE = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   output logic [WIDTH-1:0]          aut_a,
   output logic [WIDTH-1:0]          aut_b,
   output logic                      aut_cin,
   input  logic [WIDTH:0]            aut_sum,
   output logic                      busy,
   output logic                      done,
   output logic                      pass,
   output logic [WIDTH-1:0]          stage_fail,
   output logic [$clog2(WIDTH)-1:0]  first_fail,
   output logic [$clog2(8*WIDTH):0]  err_count
);

   localparam int unsigned SW   = $clog2(WIDTH);
   localparam int unsigned EW   = $clog2(8*WIDTH) + 1;
   localparam int unsigned CW   = 4;
   localparam int unsigned SUMW = WIDTH + 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_APPLY = 3'd1,
      S_WAIT  = 3'd2,
      S_CHECK = 3'd3,
      S_DONE  = 3'd4
   } state_e;

   state_e            state_q, state_d;
   logic [SW-1:0]     stage_q, stage_d;
   logic [2:0]        k_q, k_d;
   logic [CW-1:0]     wait_q, wait_d;
   logic [WIDTH-1:0]  aut_a_q, aut_a_d;
   logic [WIDTH-1:0]  aut_b_q, aut_b_d;
   logic              aut_cin_q, aut_cin_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic [WIDTH-1:0]  stage_fail_q, stage_fail_d;
   logic [SW-1:0]     first_fail_q, first_fail_d;
   logic [EW-1:0]     err_count_q, err_count_d;

   logic              accept;
   logic              wait_last;
   logic              last_vec;
   logic [SUMW-1:0]   expected;
   logic              mismatch;

   assign accept    = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;
   assign wait_last = (wait_q == CW'(SETTLE - 1));
   assign last_vec  = (stage_q == SW'(WIDTH - 1)) && (k_q == 3'd7);
   assign expected  = SUMW'(aut_a_q) + SUMW'(aut_b_q) + SUMW'(aut_cin_q);
   assign mismatch  = (aut_sum != expected);

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: if (start) state_d = S_APPLY;
         S_APPLY:        state_d = S_WAIT;
         S_WAIT:         if (wait_last) state_d = S_CHECK;
         S_CHECK:        state_d = last_vec ? S_DONE : S_APPLY;
         default:        state_d = S_IDLE;
      endcase
   end

   // Datapath and registered-output next values
   always_comb begin
      stage_d      = stage_q;
      k_d          = k_q;
      wait_d       = wait_q;
      stage_fail_d = stage_fail_q;
      first_fail_d = first_fail_q;
      err_count_d  = err_count_q;
      aut_a_d      = '0;
      aut_b_d      = '0;
      aut_cin_d    = 1'b0;

      if (accept) begin
         stage_d      = '0;
         k_d          = '0;
         stage_fail_d = '0;
         first_fail_d = '0;
         err_count_d  = '0;
      end

      case (state_q)
         S_APPLY: wait_d = '0;
         S_WAIT:  wait_d = wait_q + CW'(1);
         S_CHECK: begin
            if (mismatch) begin
               for (int j = 0; j < int'(WIDTH); j++) begin
                  if (j == int'(stage_q)) stage_fail_d[j] = 1'b1;
               end
               if (err_count_q != '1) err_count_d = err_count_q + EW'(1);
               if (err_count_q == '0) first_fail_d = stage_q;
            end
            if (!last_vec) begin
               k_d = k_q + 3'd1;
               if (k_q == 3'd7) stage_d = stage_q + SW'(1);
            end
         end
         default: ;
      endcase

      // Stage i sees k[2]/k[1] on its own operands; its carry-in is k[0],
      // supplied directly for stage 0 or generated by stage i-1 (a=b=k[0]).
      if (state_d == S_APPLY) begin
         for (int j = 0; j < int'(WIDTH); j++) begin
            if (j == int'(stage_d)) begin
               aut_a_d[j] = k_d[2];
               aut_b_d[j] = k_d[1];
            end
            if (j + 1 == int'(stage_d)) begin
               aut_a_d[j] = k_d[0];
               aut_b_d[j] = k_d[0];
            end
         end
         aut_cin_d = (stage_d == '0) ? k_d[0] : 1'b0;
      end else if ((state_d == S_WAIT) || (state_d == S_CHECK)) begin
         aut_a_d   = aut_a_q;
         aut_b_d   = aut_b_q;
         aut_cin_d = aut_cin_q;
      end

      busy_d = (state_d == S_APPLY) || (state_d == S_WAIT) || (state_d == S_CHECK);
      done_d = (state_d == S_DONE);
      pass_d = (state_d == S_DONE) && (err_count_d == '0);
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stage_q      <= '0;
         k_q          <= '0;
         wait_q       <= '0;
         aut_a_q      <= '0;
         aut_b_q      <= '0;
         aut_cin_q    <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         stage_fail_q <= '0;
         first_fail_q <= '0;
         err_count_q  <= '0;
      end else begin
         stage_q      <= stage_d;
         k_q          <= k_d;
         wait_q       <= wait_d;
         aut_a_q      <= aut_a_d;
         aut_b_q      <= aut_b_d;
         aut_cin_q    <= aut_cin_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
         stage_fail_q <= stage_fail_d;
         first_fail_q <= first_fail_d;
         err_count_q  <= err_count_d;
      end
   end

   assign aut_a      = aut_a_q;
   assign aut_b      = aut_b_q;
   assign aut_cin    = aut_cin_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign stage_fail = stage_fail_q;
   assign first_fail = first_fail_q;
   assign err_count  = err_count_q;

endmodule

// File: tb/tb_adder_fault_locator.sv
// Bench for adder_fault_locator: an 8-bit/SETTLE=1 instance driven through
// directed and randomly chosen adder faults, plus a 4-bit/SETTLE=3 instance.
module tb_adder_fault_locator;

   localparam int W8 = 8;
   localparam int S8 = 1;
   localparam int W4 = 4;
   localparam int S4 = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   always #5 clk = ~clk;

   logic       start8;
   logic [7:0] a8, b8, sf8;
   logic       cin8, busy8, done8, pass8;
   logic [8:0] sum8;
   logic [2:0] ff8;
   logic [6:0] ec8;
   int         kind8, stg8;

   logic       start4;
   logic [3:0] a4, b4, sf4;
   logic       cin4, busy4, done4, pass4;
   logic [4:0] sum4;
   logic [1:0] ff4;
   logic [5:0] ec4;

   int n_checks = 0;
   int n_fail   = 0;

   adder_fault_locator #(.WIDTH(W8), .SETTLE(S8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8),
      .aut_a(a8), .aut_b(b8), .aut_cin(cin8), .aut_sum(sum8),
      .busy(busy8), .done(done8), .pass(pass8),
      .stage_fail(sf8), .first_fail(ff8), .err_count(ec8)
   );

   adder_fault_locator #(.WIDTH(W4), .SETTLE(S4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4),
      .aut_a(a4), .aut_b(b4), .aut_cin(cin4), .aut_sum(sum4),
      .busy(busy4), .done(done4), .pass(pass4),
      .stage_fail(sf4), .first_fail(ff4), .err_count(ec4)
   );

   // Ripple adder under test with one optional fault at stage stg:
   // 1 sum inverted, 2 cout stuck-0, 3 cout stuck-1, 4 sum stuck-0.
   function automatic logic [31:0] aut_fn(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic cin,
                                          input int kind, input int stg);
      logic c, s, co;
      logic [31:0] r;
      c = cin;
      r = '0;
      for (int j = 0; j < w; j++) begin
         s  = a[j] ^ b[j] ^ c;
         co = (a[j] & b[j]) | (c & (a[j] ^ b[j]));
         if (j == stg) begin
            case (kind)
               1: s  = ~s;
               2: co = 1'b0;
               3: co = 1'b1;
               4: s  = 1'b0;
               default: ;
            endcase
         end
         r[j] = s;
         c    = co;
      end
      r[w] = c;
      return r;
   endfunction

   always_comb sum8 = 9'(aut_fn(W8, 32'(a8), 32'(b8), cin8, kind8, stg8));
   always_comb sum4 = 5'(aut_fn(W4, 32'(a4), 32'(b4), cin4, 0, 0));

   function automatic logic [31:0] vec_a(input int i, input int k);
      return 32'(((k >> 2) & 1) << i) | ((i > 0) ? 32'((k & 1) << (i - 1)) : 32'd0);
   endfunction

   function automatic logic [31:0] vec_b(input int i, input int k);
      return 32'(((k >> 1) & 1) << i) | ((i > 0) ? 32'((k & 1) << (i - 1)) : 32'd0);
   endfunction

   function automatic logic vec_cin(input int i, input int k);
      return (i == 0) ? 1'(k & 1) : 1'b0;
   endfunction

   // Expected run results: enumerate every vector with plain arithmetic.
   task automatic ref_run(input int w, input int kind, input int stg,
                          output logic [31:0] sf, output int ff, output int ec,
                          output bit bit3);
      logic [31:0] a, b, got, expv, diff;
      sf = '0; ff = 0; ec = 0; bit3 = 1'b0;
      for (int i = 0; i < w; i++) begin
         for (int k = 0; k < 8; k++) begin
            a    = vec_a(i, k);
            b    = vec_b(i, k);
            got  = aut_fn(w, a, b, vec_cin(i, k), kind, stg);
            expv = a + b + 32'(vec_cin(i, k));
            if (got != expv) begin
               if (ec == 0) ff = i;
               ec++;
               sf[i] = 1'b1;
               diff = got ^ expv;
               if (diff[3]) bit3 = 1'b1;
            end
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   // One 8-bit run; starts at a negedge, ends at the negedge of the DONE cycle.
   // abort_c >= 0 pulses reset in that run cycle instead of finishing.
   task automatic run_w8(input int kind, input int stg, input bit hold, input int abort_c);
      logic [31:0] sf, diff;
      int ff, ec, n, v;
      bit b3, seen3;
      n = 8 * W8 * (S8 + 2);
      kind8 = kind;
      stg8  = stg;
      seen3 = 1'b0;
      ref_run(W8, kind, stg, sf, ff, ec, b3);
      start8 = 1'b1;
      @(negedge clk);
      if (!hold) start8 = 1'b0;
      check("clear_err_count", 32'(ec8), 0);
      check("clear_stage_fail", 32'(sf8), 0);
      check("clear_first_fail", 32'(ff8), 0);
      check("clear_pass", 32'(pass8), 0);
      for (int c = 0; c < n; c++) begin
         v = c / (S8 + 2);
         if (c == abort_c) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            check("abort_zero", {a8, b8, 7'(cin8), busy8, done8, pass8, 4'(ff8)}, 0);
            check("abort_zero2", {sf8, 9'(ec8)}, 0);
            for (int t = 0; t < 20; t++) begin
               @(negedge clk);
               check("abort_no_done", {30'd0, busy8, done8}, 0);
            end
            return;
         end
         check($sformatf("busy c=%0d", c), 32'(busy8), 1);
         check($sformatf("done c=%0d", c), 32'(done8), 0);
         check($sformatf("aut_a c=%0d", c), 32'(a8), vec_a(v / 8, v % 8));
         check($sformatf("aut_b c=%0d", c), 32'(b8), vec_b(v / 8, v % 8));
         check($sformatf("aut_cin c=%0d", c), 32'(cin8), 32'(vec_cin(v / 8, v % 8)));
         if ((c % (S8 + 2)) == S8 + 1) begin
            diff = 32'(sum8) ^ (32'(a8) + 32'(b8) + 32'(cin8));
            if (diff[3]) seen3 = 1'b1;
         end
         @(negedge clk);
      end
      check("end_done", 32'(done8), 1);
      check("end_busy", 32'(busy8), 0);
      check("end_pass", 32'(pass8), 32'(ec == 0));
      check("end_stage_fail", 32'(sf8), sf);
      check("end_first_fail", 32'(ff8), 32'(ff));
      check("end_err_count", 32'(ec8), 32'(ec));
      check("end_operands_zero", {a8, b8, 15'(cin8)}, 0);
      check("sum_bit3_seen", 32'(seen3), 32'(b3));
   endtask

   task automatic run_w4();
      int n, v;
      n = 8 * W4 * (S4 + 2);
      start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      for (int c = 0; c < n; c++) begin
         v = c / (S4 + 2);
         check($sformatf("w4 busy c=%0d", c), 32'(busy4), 1);
         check($sformatf("w4 operands c=%0d", c), {23'd0, a4, b4, cin4},
               {23'd0, 4'(vec_a(v / 8, v % 8)), 4'(vec_b(v / 8, v % 8)), vec_cin(v / 8, v % 8)});
         @(negedge clk);
      end
      check("w4 done", 32'(done4), 1);
      check("w4 pass", 32'(pass4), 1);
      check("w4 stage_fail", 32'(sf4), 0);
      check("w4 err_count", 32'(ec4), 0);
      check("w4 first_fail", 32'(ff4), 0);
   endtask

   initial begin
      int k, s;
      rst_n  = 1'b0;
      start8 = 1'b0;
      start4 = 1'b0;
      kind8  = 0;
      stg8   = 0;
      repeat (2) @(negedge clk);
      check("reset_8", {a8, b8, 7'(cin8), busy8, done8, pass8, 4'(ff8)}, 0);
      check("reset_8b", {sf8, 9'(ec8)}, 0);
      check("reset_4", {a4, b4, 4'(sf4), 8'(ec4), ff4, cin4, busy4, done4, pass4}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Correct adder, stage-3 inverted sum, stage-0 cout stuck-0
      run_w8(0, 0, 1'b0, -1);
      run_w8(1, 3, 1'b0, -1);
      run_w8(2, 0, 1'b0, -1);

      // start held through a faulty run, then auto-restart on a good adder
      run_w8(3, 5, 1'b1, -1);
      run_w8(0, 0, 1'b0, -1);

      // Reset wins over start while in DONE
      rst_n  = 1'b0;
      start8 = 1'b1;
      @(negedge clk);
      rst_n  = 1'b1;
      start8 = 1'b0;
      check("rst_over_start", {29'd0, busy8, done8, pass8}, 0);
      check("rst_over_start_ec", 32'(ec8), 0);
      @(negedge clk);
      check("rst_over_start_idle", 32'(busy8), 0);

      // Reset at vector (stage 4, k=5), then a fresh run
      run_w8(4, 2, 1'b0, (4 * 8 + 5) * (S8 + 2));
      run_w8(0, 0, 1'b0, -1);

      // Randomly chosen faults
      for (int r = 0; r < 4; r++) begin
         k = int'($urandom_range(0, 4));
         s = int'($urandom_range(0, 7));
         run_w8(k, s, 1'b0, -1);
      end

      run_w4();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
